// File: rtl/vga_scan_doubler.sv
// Line-doubling scan converter: captures one 15.7 kHz VCE line into a ping-pong
// buffer by master-clock position and replays it twice at 31.4 kHz.
module vga_scan_doubler #(
  parameter int LINE_CLKS = 1364,
  parameter int HS_WIDTH  = 82,
  parameter int ACT_START = 100,
  parameter int ACT_END   = 660
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic [2:0] VIDEO_R,
  input  logic [2:0] VIDEO_G,
  input  logic [2:0] VIDEO_B,
  input  logic       HSYN,
  input  logic       VSYN,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [2:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_DE
);

  localparam int          DEPTH    = LINE_CLKS / 2;
  localparam logic [10:0] IN_LAST  = 11'(LINE_CLKS - 1);
  localparam logic [9:0]  OUT_LAST = 10'(DEPTH - 1);
  localparam logic [9:0]  ACT_LO   = 10'(ACT_START);
  localparam logic [9:0]  ACT_HI   = 10'(ACT_END);
  localparam logic [9:0]  HS_W     = 10'(HS_WIDTH);

  logic        hsyn_q;
  logic        fall;
  logic [10:0] in_cnt;
  logic [9:0]  out_cnt;
  logic        wr_bank;
  logic        rd_bank;
  logic        valid;
  logic        vs_line;
  logic        vs_hold;

  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [8:0]  wr_data;

  logic        act_p0;
  logic        hs_p0;
  logic        vs_p0;

  logic [8:0]  mem0 [DEPTH];
  logic [8:0]  mem1 [DEPTH];
  logic [8:0]  q0_p1;
  logic [8:0]  q1_p1;
  logic [8:0]  pix_p1;
  logic        sel_p1;
  logic        act_p1;
  logic        hs_p1;
  logic        vs_p1;

  // Input counter stops at the last clock of a line so a missing HSYN
  // freezes capture instead of overwriting the buffer.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v < IN_LAST) ? v + 11'd1 : IN_LAST;
  endfunction

  function automatic logic [9:0] wrap_inc(input logic [9:0] v);
    return (v == OUT_LAST) ? 10'd0 : v + 10'd1;
  endfunction

  assign fall    = hsyn_q & ~HSYN;
  assign rd_bank = ~wr_bank;
  assign wr_en   = ~in_cnt[0] & (in_cnt < IN_LAST);
  assign wr_addr = in_cnt[10:1];
  assign wr_data = {VIDEO_G, VIDEO_R, VIDEO_B};

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      hsyn_q  <= 1'b1;
      in_cnt  <= IN_LAST;
      out_cnt <= 10'd0;
      wr_bank <= 1'b0;
      valid   <= 1'b0;
      vs_line <= 1'b1;
      vs_hold <= 1'b1;
    end else begin
      hsyn_q  <= HSYN;
      vs_hold <= vs_p0;
      if (fall) begin
        in_cnt  <= 11'd0;
        out_cnt <= 10'd0;
        wr_bank <= ~wr_bank;
        valid   <= 1'b1;
        vs_line <= VSYN;
      end else begin
        in_cnt  <= sat_inc(in_cnt);
        out_cnt <= wrap_inc(out_cnt);
      end
    end
  end

  // Stage p0: timing decode from the output counter. VS only changes at the
  // start of an output line so both replays of a line carry the same level.
  always_comb begin
    act_p0 = valid & (out_cnt >= ACT_LO) & (out_cnt < ACT_HI);
    hs_p0  = ~(out_cnt < HS_W);
    vs_p0  = (out_cnt == 10'd0) ? vs_line : vs_hold;
  end

  // Stage p0 -> p1: ping-pong line RAM, write bank and read bank never coincide.
  always_ff @(posedge clock) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= wr_data;
    if (wr_en &&  wr_bank) mem1[wr_addr] <= wr_data;
    q0_p1 <= mem0[out_cnt];
    q1_p1 <= mem1[out_cnt];
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      sel_p1 <= 1'b0;
      act_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      sel_p1 <= rd_bank;
      act_p1 <= act_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
    end
  end

  assign pix_p1 = sel_p1 ? q1_p1 : q0_p1;

  // Stage p1 -> p2: output registers, colour blanked outside the active region.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      VGA_G  <= 3'd0;
      VGA_R  <= 3'd0;
      VGA_B  <= 3'd0;
      VGA_DE <= 1'b0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_G  <= act_p1 ? pix_p1[8:6] : 3'd0;
      VGA_R  <= act_p1 ? pix_p1[5:3] : 3'd0;
      VGA_B  <= act_p1 ? pix_p1[2:0] : 3'd0;
      VGA_DE <= act_p1;
      VGA_HS <= hs_p1;
      VGA_VS <= vs_p1;
    end
  end

endmodule
